inhibit_seq_unit: RTL and testbench

- Parametrised, clocked successor to the two-input inhibit gate (s = ~a & b).
- Evaluates one of four selectable bitwise two-operand functions on WIDTH-bit operands.
- Operands come from an external valid/ready stream or from a built-in sweep sequencer that enumerates the full truth table. The sequencer lets benches and the board demo print "m a b s" tables without testbench loops.
- Results are queued in a DEPTH-entry output FIFO with a valid/ready handshake.

---
 rtl/inhibit_seq_unit_if.sv | 31 +++
 rtl/inhibit_seq_unit.sv | 145 ++++++++++++++
 tb/tb_inhibit_seq_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inhibit_seq_unit_if.sv
// Operand/result stream bundle for inhibit_seq_unit: control, input pair handshake,
// FIFO head handshake and sweep status.
interface inhibit_seq_unit_if #(
    parameter int unsigned WIDTH = 4
);
    logic [1:0]         op;
    logic               sweep_start;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_m;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic [WIDTH-1:0]   out_s;
    logic [2:0]         out_ones;
    logic               busy;
    logic               done;

    modport slave (
        input  op, sweep_start, in_valid, a, b, out_ready,
        output in_ready, out_valid, out_m, out_a, out_b, out_s, out_ones, busy, done
    );

    modport master (
        output op, sweep_start, in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_m, out_a, out_b, out_s, out_ones, busy, done
    );
endinterface

// File: rtl/inhibit_seq_unit.sv
// Selectable bitwise two-operand function unit fed by an external stream or a
// truth-table sweep sequencer, with results queued in a first-word-fall-through FIFO.
module inhibit_seq_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    inhibit_seq_unit_if.slave bus
);
    localparam int unsigned MW = 2 * WIDTH;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]    CntFull = (PW + 1)'(DEPTH);
    localparam logic [MW-1:0]  MLast   = {MW{1'b1}};

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [MW-1:0]   m_q;
    logic [MW-1:0]   ext_idx_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic [MW-1:0]   mem_m [DEPTH];
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_s [DEPTH];

    logic             full, empty, pop, in_ready, ext_xfer, sweep_push, push;
    logic [PW-1:0]    head_idx;
    logic [MW-1:0]    push_m;
    logic [WIDTH-1:0] push_a, push_b, push_s;
    logic [2:0]       ones;

    function automatic logic [WIDTH-1:0] bitfn(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (sel)
            2'b00:   return ~x & y;
            2'b01:   return x & ~y;
            2'b10:   return ~(x | y);
            default: return ~(x ^ y);
        endcase
    endfunction

    always_comb begin
        full       = (count_q == CntFull);
        empty      = (count_q == '0);
        pop        = !empty && bus.out_ready;
        in_ready   = (state_q == StIdle) && !full && !reset;
        ext_xfer   = bus.in_valid && in_ready;
        // A pop at full frees the slot this push lands in, so the sweep keeps pace.
        sweep_push = (state_q == StSweep) && (!full || pop);
        push       = ext_xfer || sweep_push;
        if (state_q == StSweep) begin
            push_m = m_q;
            push_a = m_q[MW-1:WIDTH];
            push_b = m_q[WIDTH-1:0];
            push_s = bitfn(op_q, m_q[MW-1:WIDTH], m_q[WIDTH-1:0]);
        end else begin
            push_m = ext_idx_q;
            push_a = bus.a;
            push_b = bus.b;
            push_s = bitfn(bus.op, bus.a, bus.b);
        end
        // When empty, show the most recently popped slot so head fields hold.
        head_idx = empty ? rd_ptr_q - PW'(1) : rd_ptr_q;
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 3'(mem_s[head_idx][i]);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !empty;
    assign bus.out_m     = mem_m[head_idx];
    assign bus.out_a     = mem_a[head_idx];
    assign bus.out_b     = mem_b[head_idx];
    assign bus.out_s     = mem_s[head_idx];
    assign bus.out_ones  = ones;
    assign bus.busy      = (state_q == StSweep) || (state_q == StDone);
    assign bus.done      = (state_q == StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            m_q       <= '0;
            ext_idx_q <= '0;
        end else begin
            if (ext_xfer) begin
                ext_idx_q <= ext_idx_q + MW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (bus.sweep_start) begin
                        op_q    <= bus.op;
                        m_q     <= '0;
                        state_q <= StSweep;
                    end
                end
                StSweep: begin
                    if (sweep_push) begin
                        m_q <= m_q + MW'(1);
                        if (m_q == MLast) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i] <= '0;
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_s[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_m[wr_ptr_q] <= push_m;
                mem_a[wr_ptr_q] <= push_a;
                mem_b[wr_ptr_q] <= push_b;
                mem_s[wr_ptr_q] <= push_s;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_inhibit_seq_unit.sv
// Directed bench for inhibit_seq_unit: three instances (WIDTH 1, 2, 4) exercised in
// sequence against hand-computed rows.
module tb_inhibit_seq_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   idx;
    int   done_cnt;

    always #5 clk = ~clk;

    inhibit_seq_unit_if #(.WIDTH(1)) if1 ();
    inhibit_seq_unit_if #(.WIDTH(2)) if2 ();
    inhibit_seq_unit_if #(.WIDTH(4)) if4 ();

    inhibit_seq_unit #(.WIDTH(1), .DEPTH(2)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
    inhibit_seq_unit #(.WIDTH(2), .DEPTH(2)) u_d2 (.clk(clk), .reset(reset), .bus(if2));
    inhibit_seq_unit #(.WIDTH(4), .DEPTH(2)) u_d4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [1:0] sel, input logic [3:0] x,
                                         input logic [3:0] y, input int w);
        logic [3:0] r;
        logic [3:0] mask;
        case (sel)
            2'b00:   r = ~x & y;
            2'b01:   r = x & ~y;
            2'b10:   r = ~(x | y);
            default: r = ~(x ^ y);
        endcase
        mask = 4'((1 << w) - 1);
        return r & mask;
    endfunction

    initial begin
        logic [3:0] exp_s1 [4];
        logic [3:0] exp_s4 [4];
        logic [1:0] ones4 [4];
        exp_s1 = '{4'd0, 4'd1, 4'd0, 4'd0};
        exp_s4 = '{4'b0100, 4'b0010, 4'b1000, 4'b1001};
        ones4  = '{2'd1, 2'd1, 2'd1, 2'd2};

        {if1.op, if1.sweep_start, if1.in_valid, if1.a, if1.b, if1.out_ready} = '0;
        {if2.op, if2.sweep_start, if2.in_valid, if2.a, if2.b, if2.out_ready} = '0;
        {if4.op, if4.sweep_start, if4.in_valid, if4.a, if4.b, if4.out_ready} = '0;

        // Reset state
        #1;
        check("rst_in_ready", if2.in_ready, 0);
        check("rst_out_valid", if2.out_valid, 0);
        check("rst_busy", if2.busy, 0);
        check("rst_done", if2.done, 0);
        check("rst_out_m", if2.out_m, 0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", if2.in_ready, 1);

        // WIDTH=1 sweep, op=00
        if1.op = 2'b00;
        if1.out_ready = 1'b1;
        if1.sweep_start = 1'b1;
        tick;
        if1.sweep_start = 1'b0;
        check("w1_busy_start", if1.busy, 1);
        check("w1_valid_start", if1.out_valid, 0);
        for (int r = 0; r < 4; r++) begin
            tick;
            check("w1_valid", if1.out_valid, 1);
            check("w1_m", if1.out_m, r);
            check("w1_a", if1.out_a, r >> 1);
            check("w1_b", if1.out_b, r & 1);
            check("w1_s", if1.out_s, exp_s1[r]);
            check("w1_done", if1.done, (r == 3) ? 1 : 0);
            check("w1_busy", if1.busy, 1);
        end
        tick;
        check("w1_done_end", if1.done, 0);
        check("w1_busy_end", if1.busy, 0);
        check("w1_valid_end", if1.out_valid, 0);

        // WIDTH=4 external pair under each op
        if4.a = 4'b0011;
        if4.b = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if4.op = 2'(k);
            if4.in_valid = 1'b1;
            #1;
            check("w4_in_ready", if4.in_ready, 1);
            check("w4_valid_pre", if4.out_valid, 0);
            tick;
            if4.in_valid = 1'b0;
            check("w4_valid", if4.out_valid, 1);
            check("w4_s", if4.out_s, exp_s4[k]);
            check("w4_ones", if4.out_ones, ones4[k]);
            check("w4_m", if4.out_m, k);
            if4.out_ready = 1'b1;
            tick;
            if4.out_ready = 1'b0;
            check("w4_valid_pop", if4.out_valid, 0);
            check("w4_s_hold", if4.out_s, exp_s4[k]);
        end

        // WIDTH=2 sweep stalled by a full FIFO, then drained
        if2.op = 2'b00;
        if2.out_ready = 1'b0;
        if2.sweep_start = 1'b1;
        tick;
        if2.sweep_start = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (if2.done) done_cnt++;
        end
        check("w2_stall_valid", if2.out_valid, 1);
        check("w2_stall_head", if2.out_m, 0);
        check("w2_stall_in_ready", if2.in_ready, 0);
        if2.out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            #0;
            if (if2.out_valid) begin
                check("w2_row_m", if2.out_m, idx);
                check("w2_row_s", if2.out_s, model(2'b00, 4'(idx >> 2), 4'(idx & 3), 2));
                idx++;
            end
            if (if2.done) done_cnt++;
            tick;
        end
        check("w2_row_count", idx, 16);
        check("w2_done_count", done_cnt, 1);
        check("w2_busy_end", if2.busy, 0);

        // Reset at m=5 of a WIDTH=2 sweep
        if2.sweep_start = 1'b1;
        tick;
        if2.sweep_start = 1'b0;
        for (int c = 0; c < 6; c++) tick;
        check("rs_head_m5", if2.out_m, 5);
        #2;
        reset = 1'b1;
        #1;
        check("rs_valid", if2.out_valid, 0);
        check("rs_busy", if2.busy, 0);
        check("rs_in_ready", if2.in_ready, 0);
        check("rs_out_m", if2.out_m, 0);
        check("rs_out_s", if2.out_s, 0);
        tick;
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (if2.done) done_cnt++;
        end
        check("rs_no_done", done_cnt, 0);
        check("rs_busy_after", if2.busy, 0);
        check("rs_in_ready_after", if2.in_ready, 1);
        check("rs_valid_after", if2.out_valid, 0);

        // Sweep ignores sweep_start, op changes and in_valid
        if2.op = 2'b00;
        if2.out_ready = 1'b1;
        if2.sweep_start = 1'b1;
        tick;
        if2.sweep_start = 1'b0;
        if2.in_valid = 1'b1;
        if2.a = 2'd1;
        if2.b = 2'd2;
        idx = 0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if2.op = 2'(c);
            if2.sweep_start = (c == 3);
            #1;
            if (if2.busy) check("sw_in_ready", if2.in_ready, 0);
            if (if2.out_valid) begin
                check("sw_row_m", if2.out_m, idx);
                check("sw_row_s", if2.out_s, model(2'b00, 4'(idx >> 2), 4'(idx & 3), 2));
                idx++;
            end
            if (if2.done) begin
                done_cnt++;
                if2.in_valid = 1'b0;
            end
            tick;
        end
        if2.sweep_start = 1'b0;
        check("sw_row_count", idx, 16);
        check("sw_done_count", done_cnt, 1);
        check("sw_valid_end", if2.out_valid, 0);

        // Full FIFO, pops and external pushes keep order
        if2.op = 2'b00;
        if2.out_ready = 1'b0;
        if2.in_valid = 1'b1;
        if2.a = 2'd1;
        if2.b = 2'd2;
        tick;
        if2.a = 2'd2;
        if2.b = 2'd1;
        tick;
        if2.a = 2'd3;
        if2.b = 2'd3;
        #1;
        check("ff_full_in_ready", if2.in_ready, 0);
        check("ff_head0_m", if2.out_m, 0);
        check("ff_head0_s", if2.out_s, 2);
        check("ff_head0_a", if2.out_a, 1);
        if2.out_ready = 1'b1;
        tick;
        check("ff_head1_m", if2.out_m, 1);
        check("ff_head1_s", if2.out_s, 1);
        check("ff_ready_one", if2.in_ready, 1);
        if2.out_ready = 1'b0;
        tick;
        check("ff_refull_ready", if2.in_ready, 0);
        check("ff_head1_keep", if2.out_m, 1);
        if2.out_ready = 1'b1;
        if2.a = 2'd0;
        if2.b = 2'd3;
        tick;
        check("ff_head2_m", if2.out_m, 2);
        check("ff_head2_s", if2.out_s, 0);
        check("ff_head2_a", if2.out_a, 3);
        tick;
        check("ff_swap_valid", if2.out_valid, 1);
        check("ff_head3_m", if2.out_m, 3);
        check("ff_head3_s", if2.out_s, 3);
        if2.in_valid = 1'b0;
        tick;
        check("ff_drained", if2.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
